// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state encoding, opcodes and ALU op codes for the multicycle sequencer
// Contents: state_t (4-bit FSM encoding), OP_* opcode constants, ALUOP_* alu_control codes,
//           is_wait_state() helper marking the states that hold the memory port.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        ALU_WB   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // States that own the memory port and are guarded by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared instruction/data memory port between sequencer and memory
// Signals: mem_req, i_or_d (0 = PC, 1 = ALU result), mem_read, mem_write driven by the sequencer;
//          mem_ready driven by memory when the current access completes.
interface multicycle_ctrl_if;
    logic mem_req;
    logic i_or_d;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output i_or_d,
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with limit compare
// Ports: clk, reset_n (async active-low), clear (restart at 0), count (advance one cycle),
//        expired (counter equals LIMIT; never asserted when LIMIT = 0).
module mem_wait_timer #(
    parameter int LIMIT = 15,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0] MAX_V   = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (LIMIT != 0) && (cnt_q == LIMIT_V);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V sequencer (R-type, andi, ld, sd, bne)
// Ports: clk, reset_n (async active-low); run, opcode, zero in; mem (multicycle_ctrl_if.master)
//        memory handshake; ir_write, pc_write, pc_src, alu_src, alu_op, reg_write, mem_to_reg
//        datapath strobes; busy, illegal, bus_error, state status.
// Optional: MULTICYCLE_CTRL_PERF_EN adds cycle_cnt and instret_cnt outputs.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src,
    output logic [2:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 busy,
    output logic                 illegal,
    output logic                 bus_error,
    output logic [3:0]           state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instret_cnt
`endif
);

    state_t     state_q, state_d;
    logic       end_evt;
    logic       tmr_expired;
    logic       tmr_clear;
    logic       tmr_count;

    logic       mem_req_q, mem_req_d;
    logic       i_or_d_q, i_or_d_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       pc_src_q, pc_src_d;
    logic       alu_src_q, alu_src_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic       bus_error_q, bus_error_d;

    // Next state. When mem_ready and timer expiry coincide, mem_ready is checked first.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        end_evt     = 1'b0;
        unique case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                if (mem.mem_ready) begin
                    state_d = DECODE;
                end else if (tmr_expired) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC_R, EXEC_I:           state_d = ALU_WB;
            ALU_WB, MEM_WB, BRANCH:   end_evt = 1'b1;
            MEM_ADDR: state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mem.mem_ready) begin
                    state_d = MEM_WB;
                end else if (tmr_expired) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            MEM_WR: begin
                if (mem.mem_ready) begin
                    end_evt = 1'b1;
                end else if (tmr_expired) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
        // END pseudo-state: fold straight into the next fetch or back to idle.
        if (end_evt) state_d = run ? FETCH : IDLE;
    end

    // Moore outputs are decoded from the next state and registered, so each
    // flop presents the decode of the current state with no output glitches.
    always_comb begin
        mem_req_d    = 1'b0;
        i_or_d_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        pc_src_d     = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = ALUOP_ADD;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        busy_d       = (state_d != IDLE) && (state_d != TRAP);
        unique case (state_d)
            FETCH: begin
                mem_req_d  = 1'b1;
                mem_read_d = 1'b1;
            end
            EXEC_R: alu_op_d = ALUOP_RTYPE;
            EXEC_I: begin
                alu_src_d = 1'b1;
                alu_op_d  = ALUOP_AND;
            end
            ALU_WB: begin
                reg_write_d = 1'b1;
                alu_op_d    = alu_op_q; // entered only from EXEC_R/EXEC_I
            end
            MEM_ADDR: alu_src_d = 1'b1;
            MEM_RD: begin
                mem_req_d  = 1'b1;
                i_or_d_d   = 1'b1;
                mem_read_d = 1'b1;
                alu_src_d  = 1'b1;
            end
            MEM_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            MEM_WR: begin
                mem_req_d   = 1'b1;
                i_or_d_d    = 1'b1;
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
            end
            BRANCH: pc_src_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            i_or_d_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_src_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= ALUOP_ADD;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            i_or_d_q     <= i_or_d_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            pc_src_q     <= pc_src_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            busy_q       <= busy_d;
            illegal_q    <= illegal_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Restart the timer on entry to a memory-wait state; count only stalled cycles.
    assign tmr_clear = is_wait_state(state_d) && (state_d != state_q);
    assign tmr_count = is_wait_state(state_q) && !mem.mem_ready;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .W     (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // Same-cycle handshake strobes.
    assign ir_write = (state_q == FETCH) && mem.mem_ready;
    assign pc_write = ir_write || ((state_q == BRANCH) && !zero);

    assign mem.mem_req   = mem_req_q;
    assign mem.i_or_d    = i_or_d_q;
    assign mem.mem_read  = mem_read_q;
    assign mem.mem_write = mem_write_q;
    assign pc_src        = pc_src_q;
    assign alu_src       = alu_src_q;
    assign alu_op        = alu_op_q;
    assign reg_write     = reg_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign busy          = busy_q;
    assign illegal       = illegal_q;
    assign bus_error     = bus_error_q;
    assign state         = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + (busy_q ? 32'd1 : 32'd0);
        instret_cnt_d = instret_cnt_q + (end_evt ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic [6:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg;
    logic       busy, illegal, bus_error;
    logic [2:0] alu_op;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .TMR_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mif),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .state      (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        run           = 1'b0;
        opcode        = OP_RTYPE;
        zero          = 1'b0;
        mif.mem_ready = 1'b0;
        #3;
        check("rst_state",   32'(state), 32'(IDLE));
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_alu_op",  32'(alu_op), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        tick();
        reset_n = 1'b1;

        // R-type, zero wait
        run = 1'b1; mif.mem_ready = 1'b1; opcode = OP_RTYPE;
        tick();
        check("r_c1_state",    32'(state), 32'(FETCH));
        check("r_c1_mem_read", 32'(mif.mem_read), 32'd1);
        check("r_c1_i_or_d",   32'(mif.i_or_d), 32'd0);
        check("r_c1_ir_write", 32'(ir_write), 32'd1);
        check("r_c1_pc_write", 32'(pc_write), 32'd1);
        check("r_c1_pc_src",   32'(pc_src), 32'd0);
        check("r_c1_busy",     32'(busy), 32'd1);
        run = 1'b0;
        tick();
        check("r_c2_state",    32'(state), 32'(DECODE));
        check("r_c2_ir_write", 32'(ir_write), 32'd0);
        tick();
        check("r_c3_state",    32'(state), 32'(EXEC_R));
        check("r_c3_alu_op",   32'(alu_op), 32'b111);
        check("r_c3_reg_wr",   32'(reg_write), 32'd0);
        tick();
        check("r_c4_state",    32'(state), 32'(ALU_WB));
        check("r_c4_reg_wr",   32'(reg_write), 32'd1);
        check("r_c4_m2r",      32'(mem_to_reg), 32'd0);
        tick();
        check("r_c5_state",    32'(state), 32'(IDLE));
        check("r_c5_reg_wr",   32'(reg_write), 32'd0);
        check("r_c5_busy",     32'(busy), 32'd0);

        // andi: ALU_WB keeps the EXEC_I alu_op
        run = 1'b1; opcode = OP_ITYPE;
        tick(); run = 1'b0;
        tick();
        tick();
        check("i_c3_state",   32'(state), 32'(EXEC_I));
        check("i_c3_alu_op",  32'(alu_op), 32'b010);
        check("i_c3_alu_src", 32'(alu_src), 32'd1);
        tick();
        check("i_c4_alu_op",  32'(alu_op), 32'b010);
        check("i_c4_reg_wr",  32'(reg_write), 32'd1);

        // load, data read stalled 3 cycles
        tick();
        run = 1'b1; opcode = OP_LOAD;
        tick(); run = 1'b0;
        tick();
        tick();
        check("ld_c3_state",   32'(state), 32'(MEM_ADDR));
        check("ld_c3_alu_src", 32'(alu_src), 32'd1);
        mif.mem_ready = 1'b0;
        tick();
        check("ld_c4_state",   32'(state), 32'(MEM_RD));
        check("ld_c4_i_or_d",  32'(mif.i_or_d), 32'd1);
        check("ld_c4_m2r",     32'(mem_to_reg), 32'd0);
        tick();
        tick();
        tick();
        check("ld_c7_state",   32'(state), 32'(MEM_RD));
        mif.mem_ready = 1'b1;
        tick();
        check("ld_c8_state",   32'(state), 32'(MEM_WB));
        check("ld_c8_reg_wr",  32'(reg_write), 32'd1);
        check("ld_c8_m2r",     32'(mem_to_reg), 32'd1);
        tick();
        check("ld_c9_state",   32'(state), 32'(IDLE));
        check("ld_c9_m2r",     32'(mem_to_reg), 32'd0);

        // bne twice, back to back: taken then not taken
        run = 1'b1; opcode = OP_BRANCH; zero = 1'b0;
        tick(); tick(); tick();
        check("b1_state",    32'(state), 32'(BRANCH));
        check("b1_pc_write", 32'(pc_write), 32'd1);
        check("b1_pc_src",   32'(pc_src), 32'd1);
        tick();
        check("b2_refetch",  32'(state), 32'(FETCH));
        tick(); tick();
        zero = 1'b1; run = 1'b0;
        #1;
        check("b2_state",    32'(state), 32'(BRANCH));
        check("b2_pc_write", 32'(pc_write), 32'd0);
        tick();
        check("b2_idle",     32'(state), 32'(IDLE));

        // illegal opcode traps and stays trapped
        run = 1'b1; opcode = 7'b1111111;
        tick(); tick(); tick();
        check("ill_state",   32'(state), 32'(TRAP));
        check("ill_flag",    32'(illegal), 32'd1);
        check("ill_busy",    32'(busy), 32'd0);
        repeat (20) tick();
        check("ill_hold",    32'(state), 32'(TRAP));
        check("ill_sticky",  32'(illegal), 32'd1);
        run = 1'b0;
        pulse_reset();
        check("ill_rst_st",  32'(state), 32'(IDLE));
        check("ill_rst_flg", 32'(illegal), 32'd0);

        // fetch timeout: 16 FETCH cycles then TRAP
        opcode = OP_RTYPE; mif.mem_ready = 1'b0; run = 1'b1;
        tick(); run = 1'b0;
        repeat (15) tick();
        check("to_c16_state", 32'(state), 32'(FETCH));
        check("to_c16_berr",  32'(bus_error), 32'd0);
        tick();
        check("to_c17_state", 32'(state), 32'(TRAP));
        check("to_c17_berr",  32'(bus_error), 32'd1);
        check("to_c17_req",   32'(mif.mem_req), 32'd0);
        pulse_reset();
        check("to_rst_berr",  32'(bus_error), 32'd0);

        // mem_ready on the limit cycle wins
        run = 1'b1;
        tick(); run = 1'b0;
        repeat (15) tick();
        mif.mem_ready = 1'b1;
        #1;
        check("lim_ir_write", 32'(ir_write), 32'd1);
        tick();
        check("lim_state",    32'(state), 32'(DECODE));
        check("lim_berr",     32'(bus_error), 32'd0);
        pulse_reset();

        // three back-to-back R-type instructions
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_rst_instret", instret_cnt, 32'd0);
        check("perf_rst_cycle",   cycle_cnt, 32'd0);
`endif
        run = 1'b1; opcode = OP_RTYPE;
        repeat (12) tick();
        check("r3_c12_state", 32'(state), 32'(ALU_WB));
        run = 1'b0;
        tick();
        check("r3_idle",      32'(state), 32'(IDLE));
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_instret", instret_cnt, 32'd3);
        check("perf_cycle",   cycle_cnt, 32'd12);
`endif

        // async reset in the middle of a stalled store
        run = 1'b1; opcode = OP_STORE;
        tick(); run = 1'b0;
        tick(); tick();
        mif.mem_ready = 1'b0;
        tick();
        check("sd_state",     32'(state), 32'(MEM_WR));
        check("sd_mem_write", 32'(mif.mem_write), 32'd1);
        check("sd_i_or_d",    32'(mif.i_or_d), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("sd_rst_req",   32'(mif.mem_req), 32'd0);
        check("sd_rst_write", 32'(mif.mem_write), 32'd0);
        check("sd_rst_state", 32'(state), 32'(IDLE));
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the single-cycle RISC-V datapath (ALU, register file, imm gen, shared instruction/data memory) once it is split into fetch/decode/execute/memory/writeback steps. A Moore FSM drives all datapath strobes, arbitrates the single memory port between instruction fetch and data access through a req/ready handshake, and guards every memory wait with a timeout. Supported opcodes: R-type, andi, ld, sd, bne.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready per access; 0 disables the timeout.
TMR_W, 4, width of the wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
run  in  1  enables a new instruction fetch.
opcode  in  7  IR[6:0], stable from DECODE until the next ir_write.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completed the current access this cycle.
mem_req  out  1  memory access request.
i_or_d  out  1  address source: 0 = PC (fetch), 1 = ALU result (data).
mem_read  out  1  read strobe.
mem_write  out  1  write strobe.
ir_write  out  1  latch instruction into IR.
pc_write  out  1  update PC.
pc_src  out  1  0 = PC+4, 1 = old_pc+imm.
alu_src  out  1  0 = rs2, 1 = immediate.
alu_op  out  3  to alu_control: 111 R-type, 010 andi, 000 add.
reg_write  out  1  register file write.
mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory.
busy  out  1  high in every state except IDLE and TRAP.
illegal  out  1  sticky: unsupported opcode.
bus_error  out  1  sticky: memory timeout.
state  out  4  current state, for debug.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; all outputs 0; wait counter cleared. Any access in flight is abandoned and mem_req drops immediately.
- All outputs decode from state. Exceptions: ir_write, pc_write and the DECODE/BRANCH transitions also use mem_ready, zero and opcode in the same cycle.
- IDLE: run = 1 -> FETCH; otherwise stay.
- FETCH: mem_req = 1, i_or_d = 0, mem_read = 1. On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, -> DECODE. Otherwise hold.
- DECODE (1 cycle, no strobes). Dispatch on opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; anything else -> TRAP with illegal = 1.
- EXEC_R: alu_src = 0, alu_op = 111 -> ALU_WB.
- EXEC_I: alu_src = 1, alu_op = 010 -> ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0, alu_op held from the previous state -> END.
- MEM_ADDR: alu_src = 1, alu_op = 000. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req = 1, i_or_d = 1, mem_read = 1, alu_src = 1, alu_op = 000. On mem_ready -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1 -> END.
- MEM_WR: mem_req = 1, i_or_d = 1, mem_write = 1, alu_src = 1, alu_op = 000. On mem_ready -> END.
- BRANCH: alu_src = 0, alu_op = 000, pc_src = 1, pc_write = ~zero -> END.
- END is a pseudo-state, not a real state: go to FETCH if run = 1, else IDLE. The current instruction always completes even if run drops mid-instruction.
- Wait counter: cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states while mem_ready = 0. If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT with mem_ready still 0 -> TRAP, bus_error = 1. If mem_ready arrives in the same cycle the counter hits the limit, mem_ready wins.
- TRAP: all strobes 0, busy = 0. Exits only through reset; illegal and bus_error hold until then.
- Zero-wait latencies: R-type/andi 4 cycles, ld 5, sd 4, bne 3.
- Counter saturates and never wraps.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output ports cycle_cnt [31:0] (counts cycles while busy) and instret_cnt [31:0] (increments on each END transition). Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP, 4-bit encoding);
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - alu_op codes ALUOP_ADD, ALUOP_AND, ALUOP_RTYPE.
- One sub-module, mem_wait_timer: clear, count, limit compare, expired output.

Test Plan:
- run = 1, opcode 0110011, mem_ready always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write high exactly 1 cycle in cycle 4; ir_write and pc_write high in cycle 1.
- Load opcode 0000011, mem_ready delayed 3 cycles on the data read -> MEM_RD lasts 4 cycles; mem_to_reg = 1 and reg_write = 1 together for exactly 1 cycle; 8 cycles total.
- bne opcode 1100011 run twice, zero = 0 then zero = 1 -> first: pc_write = 1 and pc_src = 1 in BRANCH; second: pc_write = 0.
- Opcode 1111111 -> TRAP after DECODE; illegal = 1, busy = 0; stays in TRAP with run = 1 for 20 cycles; reset_n pulse -> IDLE, illegal = 0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 15 -> TRAP with bus_error = 1 after 16 FETCH cycles. Repeat with mem_ready = 1 exactly on the limit cycle -> proceeds to DECODE.
- reset_n asserted low mid-MEM_WR, between clock edges -> mem_req and mem_write drop to 0 immediately; state = IDLE. With MULTICYCLE_CTRL_PERF_EN defined: instret_cnt = 0 after reset, then 3 after three R-type instructions.
